imm_gen_pipe: RTL and testbench

Parametrised, registered immediate generator for the decode stage. It decodes every RV32I/RV64I immediate format (I, S, B, U, J, plus the shift-amount variant) and sign-extends the result to XLEN. It has a valid/ready handshake on both sides, a 2-entry skid buffer so input ready comes from a register, and a flush. It sits between the fetch/instruction register and the register-read/ALU operand mux.

---
 rtl/imm_gen_pipe.sv | 180 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate decoder with a 2-entry skid buffer.
// Latency: 1 cycle from input handshake to out_* (when the main slot is free or draining).
// Backpressure: in_ready is a register, low only while the skid entry is occupied; flush kills both entries.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        input handshake; in_inst + in_tag captured on acceptance
//   flush                    synchronous kill of both entries and of any same-cycle input
//   out_valid/out_ready      output handshake; out_imm/out_fmt/out_illegal/out_tag held while stalled
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] F_I     = 3'd0;
    localparam logic [2:0] F_S     = 3'd1;
    localparam logic [2:0] F_B     = 3'd2;
    localparam logic [2:0] F_U     = 3'd3;
    localparam logic [2:0] F_J     = 3'd4;
    localparam logic [2:0] F_SHAMT = 3'd5;
    localparam logic [2:0] F_CSR   = 3'd6;
    localparam logic [2:0] F_NONE  = 3'd7;

    // ---------------- combinational decode ----------------
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_ill;
    logic [31:0]     w_u32;

    // U-type value is formed at 32 bits and then sign-extended from bit 31,
    // which keeps the replication count positive for both XLEN builds.
    assign w_u32 = {in_inst[31:12], 12'b0};

    always_comb begin
        w_imm = '0;
        w_fmt = F_NONE;
        w_ill = 1'b0;
        case (in_inst[6:0])
            7'b0000011, 7'b1100111: begin
                w_fmt = F_I;
                w_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
            end
            7'b0010011: begin
                // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount
                if (in_inst[13:12] == 2'b01) begin
                    w_fmt = F_SHAMT;
                    if (XLEN == 32)
                        w_imm = {{(XLEN-5){1'b0}}, in_inst[24:20]};
                    else
                        w_imm = {{(XLEN-6){1'b0}}, in_inst[25:20]};
                end else begin
                    w_fmt = F_I;
                    w_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
                end
            end
            7'b0100011: begin
                w_fmt = F_S;
                w_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                w_fmt = F_B;
                w_imm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                         in_inst[30:25], in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_fmt = F_U;
                w_imm = {{(XLEN-31){w_u32[31]}}, w_u32[30:0]};
            end
            7'b1101111: begin
                w_fmt = F_J;
                w_imm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                         in_inst[20], in_inst[30:21], 1'b0};
            end
            7'b1110011: begin
                w_fmt = F_CSR;
                w_imm = {{(XLEN-5){1'b0}}, in_inst[19:15]};
            end
            7'b0110011, 7'b0001111: begin
                w_fmt = F_NONE;
            end
            default: begin
                w_fmt = F_NONE;
                w_ill = 1'b1;
            end
        endcase
    end

    // ---------------- two-entry buffer ----------------
    logic             r_m_vld, r_s_vld, r_in_rdy;
    logic [XLEN-1:0]  r_m_imm, r_s_imm;
    logic [2:0]       r_m_fmt, r_s_fmt;
    logic             r_m_ill, r_s_ill;
    logic [TAG_W-1:0] r_m_tag, r_s_tag;

    logic w_acc, w_main_free, w_to_skid, w_s_vld_nxt;

    assign w_acc       = in_valid && r_in_rdy;
    // main slot can take new content this edge: empty, or its entry leaves
    assign w_main_free = !r_m_vld || out_ready;
    assign w_to_skid   = !flush && !r_s_vld && w_acc && !w_main_free;

    always_comb begin
        w_s_vld_nxt = r_s_vld;
        if (flush)
            w_s_vld_nxt = 1'b0;
        else if (r_s_vld && w_main_free)
            w_s_vld_nxt = 1'b0;
        else if (w_to_skid)
            w_s_vld_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_vld  <= 1'b0;
            r_s_vld  <= 1'b0;
            r_in_rdy <= 1'b1;
            r_m_imm  <= '0;
            r_m_fmt  <= F_NONE;
            r_m_ill  <= 1'b0;
            r_m_tag  <= '0;
            r_s_imm  <= '0;
            r_s_fmt  <= F_NONE;
            r_s_ill  <= 1'b0;
            r_s_tag  <= '0;
        end else begin
            r_s_vld  <= w_s_vld_nxt;
            // ready mirrors the next skid state so it leaves a flop directly
            r_in_rdy <= !w_s_vld_nxt;

            if (flush) begin
                r_m_vld <= 1'b0;
            end else if (w_main_free) begin
                if (r_s_vld) begin
                    r_m_vld <= 1'b1;
                    r_m_imm <= r_s_imm;
                    r_m_fmt <= r_s_fmt;
                    r_m_ill <= r_s_ill;
                    r_m_tag <= r_s_tag;
                end else if (w_acc) begin
                    r_m_vld <= 1'b1;
                    r_m_imm <= w_imm;
                    r_m_fmt <= w_fmt;
                    r_m_ill <= w_ill;
                    r_m_tag <= in_tag;
                end else begin
                    r_m_vld <= 1'b0;
                end
            end

            if (w_to_skid) begin
                r_s_imm <= w_imm;
                r_s_fmt <= w_fmt;
                r_s_ill <= w_ill;
                r_s_tag <= in_tag;
            end
        end
    end

    assign in_ready    = r_in_rdy;
    assign out_valid   = r_m_vld;
    assign out_imm     = r_m_imm;
    assign out_fmt     = r_m_fmt;
    assign out_illegal = r_m_ill;
    assign out_tag     = r_m_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, flush;
    logic [31:0] in_inst;
    logic [4:0]  in_tag;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [4:0]  a_out_tag;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;
    logic [4:0]  b_out_tag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_tag(in_tag), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
        .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .out_tag(a_out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_tag(in_tag), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
        .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .out_tag(b_out_tag)
    );

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  tag;
    } ent_t;

    // Reference decode: field values assembled with integer arithmetic, then
    // wrapped into signed range by subtracting 2^width when the top bit is set.
    function automatic void ref_dec(input logic [31:0] inst, input int xlen,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        longint v;
        v   = 0;
        fmt = 3'd7;
        ill = 1'b0;
        case (inst[6:0])
            7'h03, 7'h67: begin
                fmt = 3'd0; v = longint'(inst[31:20]);
                if (v >= 2048) v = v - 4096;
            end
            7'h13: begin
                if (inst[14:12] == 3'd1 || inst[14:12] == 3'd5) begin
                    fmt = 3'd5;
                    v = (xlen == 32) ? (longint'(inst[31:20]) % 32) : (longint'(inst[31:20]) % 64);
                end else begin
                    fmt = 3'd0; v = longint'(inst[31:20]);
                    if (v >= 2048) v = v - 4096;
                end
            end
            7'h23: begin
                fmt = 3'd1; v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
                if (v >= 2048) v = v - 4096;
            end
            7'h63: begin
                fmt = 3'd2;
                v = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
                  + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
                if (v >= 4096) v = v - 8192;
            end
            7'h37, 7'h17: begin
                fmt = 3'd3; v = longint'(inst[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
            end
            7'h6F: begin
                fmt = 3'd4;
                v = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
                  + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
                if (v >= 1048576) v = v - 2097152;
            end
            7'h73: begin
                fmt = 3'd6; v = longint'(inst[19:15]);
            end
            7'h33, 7'h0F: fmt = 3'd7;
            default: ill = 1'b1;
        endcase
        imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
    endfunction

    function automatic logic [31:0] addi_inst(input logic [4:0] t);
        addi_inst = {7'b0, t, 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_inst   = 32'h0;
        in_tag    = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_imm !== 32'h0 ||
            a_out_fmt !== 3'd7 || a_out_illegal !== 1'b0 || a_out_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset32: v=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%0d, want 0 1 0 7 0 0",
                     a_out_valid, a_in_ready, a_out_imm, a_out_fmt, a_out_illegal, a_out_tag);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_imm !== 64'h0 || b_out_fmt !== 3'd7) begin
            errors++;
            $display("FAIL reset64: v=%b rdy=%b imm=%h fmt=%0d, want 0 1 0 7",
                     b_out_valid, b_in_ready, b_out_imm, b_out_fmt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 5'd3; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_imm !== 32'hFFFFFFFF || a_out_fmt !== 3'd0 ||
            a_out_illegal !== 1'b0 || a_out_tag !== 5'd3) begin
            errors++;
            $display("FAIL addi32: v=%b imm=%h fmt=%0d ill=%b tag=%0d, want 1 ffffffff 0 0 3",
                     a_out_valid, a_out_imm, a_out_fmt, a_out_illegal, a_out_tag);
        end
        checks++;
        if (b_out_imm !== 64'hFFFFFFFF_FFFFFFFF) begin
            errors++;
            $display("FAIL addi64: imm=%h want ffffffffffffffff", b_out_imm);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_drain: out_valid=%b want 0", a_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [4];
        logic [31:0] eimm  [4];
        logic [2:0]  efmt  [4];
        insts = '{32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h001000EF};
        eimm  = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};
        efmt  = '{3'd1, 3'd2, 3'd3, 3'd4};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b want 1", i, a_in_ready);
            end
            in_valid = 1'b1; in_inst = insts[i]; in_tag = 5'(i + 10);
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b1 || a_out_imm !== eimm[i] || a_out_fmt !== efmt[i] ||
                a_out_tag !== 5'(i + 10)) begin
                errors++;
                $display("FAIL b2b[%0d]: v=%b imm=%h fmt=%0d tag=%0d, want 1 %h %0d %0d",
                         i, a_out_valid, a_out_imm, a_out_fmt, a_out_tag, eimm[i], efmt[i], i + 10);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int next_tag = 1;
        int got [$];
        logic [31:0] held_imm;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (next_tag <= 3);
            in_tag   = 5'(next_tag);
            in_inst  = addi_inst(5'(next_tag));
            if (in_valid && a_in_ready) next_tag++;
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (a_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: in_ready=%b want 0 after two accepts", a_in_ready);
                end
                held_imm = a_out_imm;
            end
            if (c >= 1) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_tag !== 5'd1 || a_out_imm !== 32'd1) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: v=%b tag=%0d imm=%h, want 1 1 00000001",
                             c, a_out_valid, a_out_tag, a_out_imm);
                end
            end
        end
        checks++;
        if (next_tag != 3) begin
            errors++;
            $display("FAIL stall_accepts: accepted=%0d want 2", next_tag - 1);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 3; c++) begin
            in_valid = (next_tag <= 3);
            in_tag   = 5'(next_tag);
            in_inst  = addi_inst(5'(next_tag));
            if (a_out_valid) got.push_back(int'(a_out_tag));
            if (in_valid && a_in_ready) next_tag++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 3) begin
            errors++;
            $display("FAIL stall_order: got %0d tags %p, want 1 2 3", got.size(), got);
        end
        @(negedge clk);
    endtask

    task automatic test_xlen64();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h03F09093; in_tag = 5'd4;
        @(negedge clk);
        checks++;
        if (b_out_imm !== 64'h3F || b_out_fmt !== 3'd5 || a_out_imm !== 32'h1F || a_out_fmt !== 3'd5) begin
            errors++;
            $display("FAIL slli: imm64=%h fmt64=%0d imm32=%h fmt32=%0d, want 3f 5 1f 5",
                     b_out_imm, b_out_fmt, a_out_imm, a_out_fmt);
        end
        in_inst = 32'h800002B7;
        @(negedge clk);
        checks++;
        if (b_out_imm !== 64'hFFFFFFFF_80000000 || a_out_imm !== 32'h80000000 || b_out_fmt !== 3'd3) begin
            errors++;
            $display("FAIL lui64: imm64=%h imm32=%h fmt=%0d, want ffffffff80000000 80000000 3",
                     b_out_imm, a_out_imm, b_out_fmt);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h0000007F; in_tag = 5'd5;
        @(negedge clk);
        checks++;
        if (a_out_illegal !== 1'b1 || a_out_imm !== 32'h0 || a_out_fmt !== 3'd7 || b_out_illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal: ill=%b imm=%h fmt=%0d ill64=%b, want 1 0 7 1",
                     a_out_illegal, a_out_imm, a_out_fmt, b_out_illegal);
        end
        in_inst = 32'h00000033;
        @(negedge clk);
        checks++;
        if (a_out_illegal !== 1'b0 || a_out_imm !== 32'h0 || a_out_fmt !== 3'd7) begin
            errors++;
            $display("FAIL add_none: ill=%b imm=%h fmt=%0d, want 0 0 7",
                     a_out_illegal, a_out_imm, a_out_fmt);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_inst = addi_inst(5'(20 + i)); in_tag = 5'(20 + i);
            @(negedge clk);
        end
        checks++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_fill: in_ready=%b out_valid=%b, want 0 1", a_in_ready, a_out_valid);
        end
        // in_ready is low so this tag would not be taken anyway; also try it with skid free below
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd25;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: out_valid=%b in_ready=%b v64=%b, want 0 1 0",
                     a_out_valid, a_in_ready, b_out_valid);
        end
        // flush with ready high: the same-cycle input must be discarded
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd26;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (a_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_leak[%0d]: out_valid=%b tag=%0d, want 0", c, a_out_valid, a_out_tag);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_rst();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_inst = addi_inst(5'(i)); in_tag = 5'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_fmt !== 3'd7 || a_out_tag !== 5'd0) begin
            errors++;
            $display("FAIL async_rst: out_valid=%b in_ready=%b fmt=%0d tag=%0d, want 0 1 7 0",
                     a_out_valid, a_in_ready, a_out_fmt, a_out_tag);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        ent_t        q [$];
        ent_t        e;
        logic [63:0] eimm;
        logic [2:0]  efmt;
        logic        eill;
        logic [6:0]  ops [12];
        bit          in_fire, out_fire;
        ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h5B};
        idle();
        for (int c = 0; c < 3000; c++) begin
            checks++;
            if (a_out_valid !== (q.size() > 0) || a_in_ready !== (q.size() < 2) ||
                b_out_valid !== (q.size() > 0) || b_in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rnd_flow[%0d]: v=%b rdy=%b v64=%b rdy64=%b, occupancy %0d",
                         c, a_out_valid, a_in_ready, b_out_valid, b_in_ready, q.size());
            end
            if (q.size() > 0) begin
                ref_dec(q[0].inst, 32, eimm, efmt, eill);
                checks++;
                if (a_out_imm !== eimm[31:0] || a_out_fmt !== efmt || a_out_illegal !== eill ||
                    a_out_tag !== q[0].tag) begin
                    errors++;
                    $display("FAIL rnd32[%0d]: inst=%h imm=%h fmt=%0d ill=%b tag=%0d, want %h %0d %b %0d",
                             c, q[0].inst, a_out_imm, a_out_fmt, a_out_illegal, a_out_tag,
                             eimm[31:0], efmt, eill, q[0].tag);
                end
                ref_dec(q[0].inst, 64, eimm, efmt, eill);
                checks++;
                if (b_out_imm !== eimm || b_out_fmt !== efmt || b_out_illegal !== eill ||
                    b_out_tag !== q[0].tag) begin
                    errors++;
                    $display("FAIL rnd64[%0d]: inst=%h imm=%h fmt=%0d ill=%b tag=%0d, want %h %0d %b %0d",
                             c, q[0].inst, b_out_imm, b_out_fmt, b_out_illegal, b_out_tag,
                             eimm, efmt, eill, q[0].tag);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = $urandom;
            if ($urandom_range(0, 7) != 0) in_inst[6:0] = ops[$urandom_range(0, 11)];
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            if (flush) begin
                q.delete();
            end else begin
                in_fire  = in_valid && (q.size() < 2);
                out_fire = out_ready && (q.size() > 0);
                if (out_fire) void'(q.pop_front());
                if (in_fire) begin
                    e.inst = in_inst;
                    e.tag  = in_tag;
                    q.push_back(e);
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_xlen64();
        test_illegal();
        test_flush();
        test_async_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
